vga_config_scheduler: RTL and testbench

- Frame-synchronous scheduler for the 32-bit VGA configuration word that drives the pixel-mux select (bits 31:30) and colour mask (bits 29:24).
- Accepts new configuration words from the host/Arduino-side interface over a valid/ready handshake and buffers them in a small FIFO.
- Commits at most one buffered word per frame, only at the start of vertical blanking, so mode and colour changes never tear mid-frame.
- Sits between the host register interface and the VGA controller's configuration input.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_config_scheduler_cfg_fifo.sv | 64 ++++++
 rtl/vga_config_scheduler.sv | 103 ++++++++++
 tb/tb_vga_config_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, configuration-word field layout and scheduler state encoding.
package vga_pkg;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_ACTIVE = 640;

  localparam int unsigned SEL_MSB  = 31;
  localparam int unsigned SEL_LSB  = 30;
  localparam int unsigned MASK_MSB = 29;
  localparam int unsigned MASK_LSB = 24;

  typedef enum logic [1:0] {
    SEL_RAND = 2'd0,
    SEL_MASK = 2'd1,
    SEL_CHAR = 2'd2,
    SEL_PONG = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DWELL = 2'd2
  } sched_state_e;
endpackage

// File: rtl/vga_config_scheduler_cfg_fifo.sv
// Circular-buffer FIFO for pending configuration words; ready is a registered decode of the count.
module cfg_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             ready_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q;
  logic             do_push, do_pop;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (flush_i)
      count_d = '0;
    else if (do_push && !do_pop)
      count_d = count_q + 1'b1;
    else if (!do_push && do_pop)
      count_d = count_q - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < CW'(DEPTH));
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ready_o = ready_q;
endmodule

// File: rtl/vga_config_scheduler.sv
// Commits at most one buffered config word per frame at the start of vertical blanking.
// States: IDLE nothing pending | ARMED word waiting for boundary | DWELL holding last commit.
module vga_config_scheduler #(
  parameter int unsigned V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned DWELL_FRAMES = 0,
  parameter logic [31:0] RESET_CFG    = 32'h0000_0000,
  localparam int unsigned PW = $clog2(DEPTH) + 1,
  localparam int unsigned DW = (DWELL_FRAMES == 0) ? 1 : $clog2(DWELL_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    y,
  input  logic [31:0]   cfg_in,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic          flush,
  output logic [31:0]   configuration,
  output logic          cfg_applied,
  output logic [PW-1:0] pending,
  output logic [7:0]    frame_count
);
  import vga_pkg::*;

  sched_state_e  state_q;
  logic [DW-1:0] dwell_q;
  logic [31:0]   cfg_q;
  logic          applied_q;
  logic [7:0]    frame_q;
  logic [9:0]    y_q;
  logic          started_q;
  logic          boundary;
  logic          commit;
  logic [31:0]   head;

  // started_q masks the first cycle out of reset, when y_q does not yet reflect y.
  assign boundary = started_q && (y == 10'(V_ACTIVE)) && (y_q != 10'(V_ACTIVE));
  assign commit   = boundary && !flush && (state_q != DWELL) && (pending != '0);

  cfg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cfg_valid),
    .pop_i   (commit),
    .flush_i (flush),
    .din_i   (cfg_in),
    .dout_o  (head),
    .count_o (pending),
    .ready_o (cfg_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dwell_q   <= '0;
      cfg_q     <= RESET_CFG;
      applied_q <= 1'b0;
      frame_q   <= 8'd0;
      y_q       <= 10'd0;
      started_q <= 1'b0;
    end else begin
      y_q       <= y;
      started_q <= 1'b1;
      applied_q <= commit;
      if (boundary) frame_q <= frame_q + 8'd1;
      if (commit)   cfg_q   <= head;
      case (state_q)
        IDLE, ARMED: begin
          if (commit) begin
            if (DWELL_FRAMES > 0) begin
              dwell_q <= DW'(DWELL_FRAMES);
              state_q <= DWELL;
            end else begin
              state_q <= (pending > PW'(1)) ? ARMED : IDLE;
            end
          end else if (flush || pending == '0) begin
            state_q <= IDLE;
          end else begin
            state_q <= ARMED;
          end
        end
        DWELL: begin
          if (boundary) begin
            if (dwell_q == DW'(1)) begin
              dwell_q <= '0;
              state_q <= (pending != '0 && !flush) ? ARMED : IDLE;
            end else begin
              dwell_q <= dwell_q - DW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign configuration = cfg_q;
  assign cfg_applied   = applied_q;
  assign frame_count   = frame_q;
endmodule

// File: tb/tb_vga_config_scheduler.sv
// Bench for vga_config_scheduler: a directed vector table, frame-level sequences and random
// traffic, with one DUT at DWELL_FRAMES=0 and one at DWELL_FRAMES=2 checked against a queue model.
module tb_vga_config_scheduler;
  localparam int DEPTH = 2;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] WA = 32'h7F00_0000;
  localparam logic [31:0] WB = 32'h4100_0000;
  localparam logic [31:0] WC = 32'hC500_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [9:0]    y = '0;
  logic          flush = 1'b0;
  logic [31:0]   din0 = '0, din2 = '0;
  logic          val0 = 1'b0, val2 = 1'b0;
  logic          rdy0, rdy2, app0, app2;
  logic [31:0]   cfg0, cfg2;
  logic [PW-1:0] pend0, pend2;
  logic [7:0]    fc0, fc2;

  vga_config_scheduler #(.DEPTH(DEPTH), .DWELL_FRAMES(0)) u0 (
    .clk(clk), .rst(rst), .y(y), .cfg_in(din0), .cfg_valid(val0), .cfg_ready(rdy0),
    .flush(flush), .configuration(cfg0), .cfg_applied(app0), .pending(pend0), .frame_count(fc0));

  vga_config_scheduler #(.DEPTH(DEPTH), .DWELL_FRAMES(2)) u2 (
    .clk(clk), .rst(rst), .y(y), .cfg_in(din2), .cfg_valid(val2), .cfg_ready(rdy2),
    .flush(flush), .configuration(cfg2), .cfg_applied(app2), .pending(pend2), .frame_count(fc2));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: FIFO contents as queues, dwell as a frame countdown, commit = boundary with no dwell left.
  logic [31:0] q0[$], q2[$];
  logic [31:0] s0[$], s2[$];
  logic [31:0] m_cfg [2];
  bit          m_app [2];
  int          m_dwell [2];
  int          m_fc;
  int          m_yprev;
  bit          m_started;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q2.size();
  endfunction

  task automatic model_step(input bit v0, input bit v2, input logic [31:0] d0, input logic [31:0] d2,
                            input int yv, input bit f, input bit r, output bit acc0, output bit acc2);
    bit bnd, push;
    int sz;
    logic [31:0] w;
    acc0 = 1'b0;
    acc2 = 1'b0;
    if (r) begin
      q0.delete(); q2.delete();
      for (int m = 0; m < 2; m++) begin
        m_cfg[m] = 32'h0; m_app[m] = 1'b0; m_dwell[m] = 0;
      end
      m_fc = 0; m_yprev = 0; m_started = 1'b0;
      return;
    end
    bnd = m_started && (yv == 480) && (m_yprev != 480);
    for (int m = 0; m < 2; m++) begin
      sz = qsize(m);
      push = ((m == 0) ? v0 : v2) && (sz < DEPTH);
      m_app[m] = 1'b0;
      if (bnd && !f && sz > 0 && m_dwell[m] == 0) begin
        if (m == 0) w = q0.pop_front(); else w = q2.pop_front();
        m_cfg[m] = w;
        m_app[m] = 1'b1;
        m_dwell[m] = (m == 0) ? 0 : 2;
      end else if (bnd && m_dwell[m] > 0) begin
        m_dwell[m]--;
      end
      if (f) begin
        if (m == 0) q0.delete(); else q2.delete();
      end else if (push) begin
        if (m == 0) q0.push_back(d0); else q2.push_back(d2);
      end
      if (m == 0) acc0 = push; else acc2 = push;
    end
    if (bnd) m_fc = (m_fc + 1) % 256;
    m_yprev = yv;
    m_started = 1'b1;
  endtask

  task automatic step(input int yv, input bit f, input bit r);
    bit a0, a2;
    y = 10'(yv);
    flush = f;
    rst = r;
    val0 = (s0.size() > 0);
    din0 = val0 ? s0[0] : 32'h0;
    val2 = (s2.size() > 0);
    din2 = val2 ? s2[0] : 32'h0;
    @(posedge clk);
    model_step(val0, val2, din0, din2, yv, f, r, a0, a2);
    if (a0) s0.delete(0);
    if (a2) s2.delete(0);
    @(negedge clk);
    chk("cfg0",  cfg0,         m_cfg[0]);
    chk("app0",  32'(app0),    32'(m_app[0]));
    chk("pend0", 32'(pend0),   32'(qsize(0)));
    chk("rdy0",  32'(rdy0),    32'(qsize(0) < DEPTH));
    chk("fc0",   32'(fc0),     32'(m_fc));
    chk("cfg2",  cfg2,         m_cfg[1]);
    chk("app2",  32'(app2),    32'(m_app[1]));
    chk("pend2", 32'(pend2),   32'(qsize(1)));
    chk("rdy2",  32'(rdy2),    32'(qsize(1) < DEPTH));
    chk("fc2",   32'(fc2),     32'(m_fc));
  endtask

  task automatic lines(input int a, input int b);
    for (int l = a; l <= b; l++) step(l, 1'b0, 1'b0);
  endtask

  task automatic load3();
    s0.delete(); s2.delete();
    s0.push_back(WA); s0.push_back(WB); s0.push_back(WC);
    s2.push_back(WA); s2.push_back(WB); s2.push_back(WC);
  endtask

  typedef struct {
    bit          r;
    int          yv;
    bit          v;
    logic [31:0] d;
    bit          f;
    logic [31:0] e_cfg;
    bit          e_app;
    int          e_pend;
    bit          e_rdy;
    int          e_fc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input int yv, input bit v, input logic [31:0] d, input bit f,
                     input logic [31:0] ec, input bit ea, input int ep, input bit er, input int ef);
    vec_t t;
    t.r = r; t.yv = yv; t.v = v; t.d = d; t.f = f;
    t.e_cfg = ec; t.e_app = ea; t.e_pend = ep; t.e_rdy = er; t.e_fc = ef;
    tbl.push_back(t);
  endtask

  initial begin
    int yy;
    bit fr, rr;

    // Directed vectors against the DWELL_FRAMES=0 instance.
    add(1, 0,   0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
    add(0, 100, 1, WA,    0, 32'h0, 0, 1, 1, 0);
    add(0, 101, 0, 32'h0, 0, 32'h0, 0, 1, 1, 0);
    add(0, 479, 0, 32'h0, 0, 32'h0, 0, 1, 1, 0);
    add(0, 480, 0, 32'h0, 0, WA,    1, 0, 1, 1);
    add(0, 480, 0, 32'h0, 0, WA,    0, 0, 1, 1);
    add(0, 481, 1, WB,    0, WA,    0, 1, 1, 1);
    add(0, 480, 0, 32'h0, 1, WA,    0, 0, 1, 2);
    add(0, 0,   0, 32'h0, 0, WA,    0, 0, 1, 2);
    add(1, 480, 1, WC,    0, 32'h0, 0, 0, 1, 0);
    add(0, 480, 0, 32'h0, 0, 32'h0, 0, 1, 1, 0);
    add(0, 480, 0, 32'h0, 0, 32'h0, 0, 1, 1, 0);
    add(0, 0,   0, 32'h0, 0, 32'h0, 0, 1, 1, 0);
    add(0, 480, 0, 32'h0, 0, WC,    1, 0, 1, 1);
    foreach (tbl[i]) begin
      if (tbl[i].v) begin
        s0.push_back(tbl[i].d);
        s2.push_back(tbl[i].d);
      end
      step(tbl[i].yv, tbl[i].f, tbl[i].r);
      chk("tbl_cfg",  cfg0,       tbl[i].e_cfg);
      chk("tbl_app",  32'(app0),  32'(tbl[i].e_app));
      chk("tbl_pend", 32'(pend0), 32'(tbl[i].e_pend));
      chk("tbl_rdy",  32'(rdy0),  32'(tbl[i].e_rdy));
      chk("tbl_fc",   32'(fc0),   32'(tbl[i].e_fc));
    end

    // Two idle frames.
    s0.delete(); s2.delete();
    step(0, 1'b0, 1'b1);
    lines(0, 524);
    lines(0, 524);
    chk("idle_fc",  32'(fc0),  32'd2);
    chk("idle_cfg", cfg0,      32'h0);
    chk("idle_rdy", 32'(rdy0), 32'd1);

    // Three words into a two-deep FIFO, one commit per frame; dwell instance holds A for two extra frames.
    step(0, 1'b0, 1'b1);
    load3();
    lines(0, 10);
    chk("abc_stall_pend", 32'(pend0), 32'd2);
    chk("abc_stall_rdy",  32'(rdy0),  32'd0);
    lines(11, 480);
    chk("abc_b1_cfg0", cfg0,      WA);
    chk("abc_b1_app0", 32'(app0), 32'd1);
    chk("abc_b1_cfg2", cfg2,      WA);
    lines(481, 482);
    chk("abc_c_accept", 32'(pend0), 32'd2);
    lines(483, 524); lines(0, 480);
    chk("abc_b2_cfg0", cfg0, WB);
    chk("dw_b2_cfg2",  cfg2, WA);
    chk("dw_b2_app2",  32'(app2), 32'd0);
    lines(481, 524); lines(0, 480);
    chk("abc_b3_cfg0", cfg0, WC);
    chk("dw_b3_cfg2",  cfg2, WA);
    lines(481, 524); lines(0, 480);
    chk("dw_b4_cfg2", cfg2,      WB);
    chk("dw_b4_app2", 32'(app2), 32'd1);
    chk("abc_b4_app0", 32'(app0), 32'd0);

    // Reset while the dwell instance is holding A with two words pending, y held at 480 across release.
    step(0, 1'b0, 1'b1);
    load3();
    lines(0, 480);
    lines(481, 490);
    chk("rst_pre_pend2", 32'(pend2), 32'd2);
    chk("rst_pre_cfg2",  cfg2,       WA);
    s0.delete(); s2.delete();
    step(480, 1'b0, 1'b1);
    chk("rst_cfg2",  cfg2,       32'h0);
    chk("rst_pend2", 32'(pend2), 32'd0);
    chk("rst_fc2",   32'(fc2),   32'd0);
    for (int k = 0; k < 3; k++) begin
      step(480, 1'b0, 1'b0);
      chk("rst_hold_fc",  32'(fc2),  32'd0);
      chk("rst_hold_app", 32'(app2), 32'd0);
    end
    lines(481, 524); lines(0, 480);
    chk("rst_after_fc",  32'(fc2), 32'd1);
    chk("rst_after_cfg", cfg2,     32'h0);

    // Random traffic with frequent jumps near the blanking line.
    step(0, 1'b0, 1'b1);
    yy = 0;
    for (int k = 0; k < 4000; k++) begin
      case ($urandom % 16)
        0, 1:    yy = yy;
        2, 3:    yy = 477 + int'($urandom % 5);
        4:       yy = int'($urandom % 525);
        default: yy = (yy + 1) % 525;
      endcase
      if (s0.size() == 0 && ($urandom % 3) == 0) s0.push_back($urandom);
      if (s2.size() == 0 && ($urandom % 3) == 0) s2.push_back($urandom);
      fr = (($urandom % 40) == 0);
      rr = (($urandom % 700) == 0);
      step(yy, fr, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
